weight_loader: RTL and testbench

WEIGHT_LOADER -- requirements
Module: weight_loader

---
 rtl/weight_loader.sv | 84 ++++++++
 tb/tb_weight_loader.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
// Streams NUM_NEURONS x NUM_INPUTS weight words from a valid/ready source into
// per-neuron memories, neuron-major, one registered write per accepted beat.
module weight_loader #(
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 10,
  parameter int DATA_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   s_valid,
  input  logic [DATA_W-1:0]      s_data,
  output logic                   s_ready,
  output logic [NUM_NEURONS-1:0] wr_en,
  output logic [9:0]             wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic                   busy,
  output logic                   done
);

  localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                 state;
  logic [9:0]             addr;
  logic [NW-1:0]          nidx;
  logic [NUM_NEURONS-1:0] sel;
  logic                   last_addr, last_nidx;

  assign last_addr = (addr == 10'(NUM_INPUTS - 1));
  assign last_nidx = (nidx == NW'(NUM_NEURONS - 1));

  // One-hot neuron select, one decoder bit per neuron memory
  for (genvar k = 0; k < NUM_NEURONS; k++) begin : g_sel
    assign sel[k] = (nidx == NW'(k));
  end

  // Status decoded straight from the state register: stable all cycle, no s_valid path
  assign s_ready = (state == LOAD);
  assign busy    = (state == LOAD);
  assign done    = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      addr    <= '0;
      nidx    <= '0;
      wr_en   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= '0;
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          addr  <= '0;
          nidx  <= '0;
        end
        LOAD: begin
          // Abort wins over a coincident beat: the beat is dropped, nothing written
          if (abort) begin
            state <= IDLE;
          end else if (s_valid) begin
            wr_en   <= sel;
            wr_addr <= addr;
            wr_data <= s_data;
            if (last_addr) begin
              addr <= '0;
              if (last_nidx) state <= DONE;
              else           nidx  <= nidx + NW'(1);
            end else begin
              addr <= addr + 10'd1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: full load, stalled load, wrap, abort,
// async reset mid-load and ignored start, against hand-computed write tuples.
module tb_weight_loader;

  localparam int NI = 784;
  localparam int NN = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, busy, done;
  logic [NN-1:0] wr_en;
  logic [9:0]    wr_addr;
  logic [DW-1:0] wr_data;

  int n_cmp = 0;
  int n_err = 0;

  weight_loader #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {wr_en, wr_addr, wr_data} for a write to neuron n, address a
  function automatic logic [63:0] wv(input int n, input int a, input logic [DW-1:0] d);
    logic [NN-1:0] oh;
    oh = '0;
    oh[n] = 1'b1;
    return 64'({oh, 10'(a), d});
  endfunction

  function automatic logic [63:0] obs();
    return 64'({wr_en, wr_addr, wr_data});
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int cnt;
    bit v;

    // Reset state
    tick(); tick();
    chk("reset_outs", 64'({wr_en, wr_addr, wr_data, busy, done, s_ready}), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("post_reset_idle", 64'({wr_en, busy, done, s_ready}), 64'd0);

    // Full load, s_valid held high, s_data = beat index
    do_start();
    chk("load_busy", 64'({busy, s_ready, done}), 64'b110);
    for (int i = 0; i < NN*NI; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(i);
      tick();
      chk("full_write", obs(), wv(i / NI, i % NI, DW'(i)));
      if (i == 783) chk("wrap_783",  obs(), wv(0, 783, DW'(783)));
      if (i == 784) chk("wrap_784",  obs(), wv(1, 0,   DW'(784)));
      if (i < NN*NI - 1) chk("full_status", 64'({s_ready, done}), 64'b10);
    end
    chk("done_pulse", 64'({done, busy, s_ready}), 64'b100);
    s_valid = 1'b0;
    tick();
    chk("after_done", 64'({done, busy, s_ready, wr_en}), 64'd0);

    // Alternating s_valid: writes only after valid cycles, gap-free addresses
    do_start();
    cnt = 0;
    v = 1'b1;
    while (cnt < NN*NI) begin
      s_valid = v;
      s_data  = DW'(cnt ^ 16'h5a5a);
      tick();
      if (v) begin
        chk("stall_write", obs(), wv(cnt / NI, cnt % NI, DW'(cnt ^ 16'h5a5a)));
        cnt++;
      end else begin
        chk("stall_idle_wr", 64'(wr_en), 64'd0);
      end
      v = ~v;
    end
    s_valid = 1'b0;
    chk("stall_total", 64'(cnt), 64'(NN*NI));
    chk("stall_done", 64'({done, s_ready}), 64'b10);
    tick();

    // Abort on beat 100 with s_valid high
    do_start();
    for (int i = 0; i < 100; i++) begin
      s_valid = 1'b1; s_data = DW'(i); tick();
    end
    chk("pre_abort_wr", obs(), wv(0, 99, DW'(99)));
    abort = 1'b1; s_data = 16'hbeef;
    tick();
    chk("abort_drop", 64'({wr_en, busy, s_ready}), 64'd0);
    abort = 1'b0; s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", 64'({done, busy}), 64'd0);
    end
    // start with abort in IDLE: abort ignored, load begins
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_ign", 64'(busy), 64'd1);
    s_valid = 1'b1; s_data = 16'hffff;
    tick();
    chk("restart_first", obs(), wv(0, 0, 16'hffff));

    // Async reset mid-load at beat 500
    for (int i = 1; i <= 500; i++) begin
      s_data = DW'(i); tick();
    end
    chk("pre_rst_wr", obs(), wv(0, 500, DW'(500)));
    #1 reset_n = 1'b0;
    #1 chk("async_rst", 64'({wr_en, busy, s_ready}), 64'd0);
    s_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    s_valid = 1'b1;
    tick();
    chk("rst_no_spur", 64'({wr_en, busy}), 64'd0);
    s_valid = 1'b0;
    do_start();
    s_valid = 1'b1; s_data = 16'h8001;
    tick();
    chk("rst_restart", obs(), wv(0, 0, 16'h8001));

    // start pulsed at beat 10 is ignored
    for (int i = 1; i <= 12; i++) begin
      s_data = DW'(i + 16'h100);
      start  = (i == 10);
      tick();
      if (i == 11) chk("start_ign_11", obs(), wv(0, 11, DW'(11 + 16'h100)));
    end
    start = 1'b0;
    chk("start_ign_busy", 64'(busy), 64'd1);
    abort = 1'b1; s_valid = 1'b0;
    tick();
    abort = 1'b0;
    chk("final_idle", 64'({busy, done, wr_en}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
